// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: load-use stalls, taken-branch squash, multi-cycle MUL/DIV hold.
// Define HAZARD_PERF_CNT_EN to add the o_stall_cycles / o_flush_events performance counters.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_branch_taken,
    input  logic       i_ex_md_start,
    input  logic       i_md_done,
    output logic       o_pc_stall,
    output logic       o_if_id_stall,
    output logic       o_if_id_flush,
    output logic       o_id_ex_flush,
    output logic       o_ex_hold,
    output logic       o_md_busy,
    output logic       o_md_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_events
`endif
);

    localparam int unsigned CntW = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [0:0] {StRun, StMdBusy} state_e;

    state_e            r_state, w_state_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_timeout, w_timeout_nxt;
    logic              w_lu;
    logic              w_stall;

    assign w_lu = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                  ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = r_timeout;
        w_stall       = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_ex_hold     = 1'b0;
        o_md_busy     = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_ex_branch_taken) begin
                    // ID holds a wrong-path instruction; md_start alongside is ignored.
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (i_ex_md_start) begin
                    if (!i_md_done) begin
                        w_stall     = 1'b1;
                        o_ex_hold   = 1'b1;
                        w_state_nxt = StMdBusy;
                        w_cnt_nxt   = CntW'(1);
                    end
                end else if (w_lu) begin
                    w_stall       = 1'b1;
                    o_id_ex_flush = 1'b1;
                end
            end
            StMdBusy: begin
                o_md_busy = 1'b1;
                if (i_md_done) begin
                    w_state_nxt = StRun;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CntW'(MD_TIMEOUT)) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = StRun;
                    w_cnt_nxt     = '0;
                end else begin
                    w_stall   = 1'b1;
                    o_ex_hold = 1'b1;
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    assign o_pc_stall    = w_stall;
    assign o_if_id_stall = w_stall;
    assign o_md_timeout  = r_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StRun;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_stall_cycles <= r_stall_cycles + {31'd0, w_stall};
            r_flush_events <= r_flush_events + {31'd0, o_if_id_flush};
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd, br, ms, md;
    logic       pc_stall, ifid_stall, ifid_flush, idex_flush, ex_hold, md_busy, md_to;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: elapsed = busy cycles so far of an in-flight MUL/DIV (0 = none).
    int          m_elapsed;
    bit          m_to;
    int unsigned m_stalls, m_flushes;

    hazard_ctrl #(.MD_TIMEOUT(TO)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_id_rs1         (rs1),
        .i_id_rs2         (rs2),
        .i_id_use_rs1     (use1),
        .i_id_use_rs2     (use2),
        .i_ex_rd          (rd),
        .i_ex_mem_read    (mrd),
        .i_ex_branch_taken(br),
        .i_ex_md_start    (ms),
        .i_md_done        (md),
        .o_pc_stall       (pc_stall),
        .o_if_id_stall    (ifid_stall),
        .o_if_id_flush    (ifid_flush),
        .o_id_ex_flush    (idex_flush),
        .o_ex_hold        (ex_hold),
        .o_md_busy        (md_busy),
        .o_md_timeout     (md_to)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cycles   (stall_cycles),
        .o_flush_events   (flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic act, input logic exp);
        n_checks++;
        assert (act === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic u1, input logic u2, input logic [4:0] d,
                         input logic m, input logic b, input logic s, input logic dn);
        rst = r; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2; rd = d;
        mrd = m; br = b; ms = s; md = dn;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit lu, e_stall, e_ifl, e_idf, e_hold, e_busy;
        @(negedge clk);
        lu = mrd && rd != 0 && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        e_stall = 0; e_ifl = 0; e_idf = 0; e_hold = 0; e_busy = (m_elapsed != 0);
        if (m_elapsed == 0) begin
            if (br) begin
                e_ifl = 1; e_idf = 1;
            end else if (ms) begin
                e_stall = !md; e_hold = !md;
            end else if (lu) begin
                e_stall = 1; e_idf = 1;
            end
        end else if (!md && m_elapsed < int'(TO)) begin
            e_stall = 1; e_hold = 1;
        end
        chk("pc_stall", pc_stall, e_stall);
        chk("if_id_stall", ifid_stall, e_stall);
        chk("if_id_flush", ifid_flush, e_ifl);
        chk("id_ex_flush", idex_flush, e_idf);
        chk("ex_hold", ex_hold, e_hold);
        chk("md_busy", md_busy, e_busy);
        chk("md_timeout", md_to, m_to);
`ifdef HAZARD_PERF_CNT_EN
        chk32("stall_cycles", stall_cycles, m_stalls);
        chk32("flush_events", flush_events, m_flushes);
`endif
        @(posedge clk);
        if (rst) begin
            m_elapsed = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls  += e_stall;
            m_flushes += e_ifl;
            if (m_elapsed == 0) begin
                if (!br && ms && !md) m_elapsed = 1;
            end else if (md) begin
                m_elapsed = 0;
            end else if (m_elapsed == int'(TO)) begin
                m_elapsed = 0; m_to = 1;
            end else begin
                m_elapsed++;
            end
        end
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_elapsed = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        idle(); step();

        // Load-use via rs2, then same with rd = x0.
        drive(0, 5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0); step();
        idle(); step();
        drive(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0); step();
        // Load-use via rs1 masked by taken branch.
        drive(0, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0, 0); step();
        // Branch and md_start together: branch wins.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0); step();
        idle(); step();

        // MUL/DIV finishing four cycles after start.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0); step();
        drive(0, 5'd3, 5'd0, 1, 0, 5'd3, 1, 1, 0, 0); step();
        idle(); step();
        idle(); step();
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1); step();
        idle(); step();

        // Single-cycle MUL/DIV with a coincident load-use.
        drive(0, 5'd4, 5'd0, 1, 0, 5'd4, 1, 0, 1, 1); step();
        idle(); step();

        // Timeout: done never arrives.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0); step();
        repeat (TO + 3) begin idle(); step(); end

        // Reset mid-MD_BUSY clears busy and the sticky timeout.
        drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0); step();
        idle(); step();
        rst = 1'b1; step();
        idle(); step();
        idle(); step();

`ifdef HAZARD_PERF_CNT_EN
        rst = 1'b1; step();
        repeat (3) begin
            drive(0, 5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0); step();
        end
        repeat (2) begin
            drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0); step();
        end
        idle(); step();
        chk32("perf_stalls_3", stall_cycles, 32'd3);
        chk32("perf_flushes_2", flush_events, 32'd2);
`endif

        // Randomized phase with small register indices so hazards occur often.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
